seq_pattern_detect: RTL and testbench

SEQ_PATTERN_DETECT -- requirements
Module: seq_pattern_detect

---
 rtl/seq_pattern_detect_pkg.sv | 16 +
 rtl/seq_pattern_detect_sat_counter.sv | 32 +++
 rtl/seq_pattern_detect.sv | 103 ++++++++++
 tb/tb_seq_pattern_detect.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_detect_pkg.sv
// Shared definitions for the serial pattern detector.
//   state_t        : detector FSM states (IDLE, FILL, HUNT)
//   N_DEFAULT      : default pattern length in bits
//   CNT_W_DEFAULT  : default width of the match counter
package seq_pattern_detect_pkg;

    localparam int unsigned N_DEFAULT     = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

endpackage

// File: rtl/seq_pattern_detect_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   inc      : add one to count (ignored once saturated)
//   clr      : zero count on the next edge; wins over inc
//   count    : current count value
//   sat      : high while count is at its maximum value
module sat_counter
    import seq_pattern_detect_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = &count;

endmodule

// File: rtl/seq_pattern_detect.sv
// Serial bit-pattern detector with overlapping / non-overlapping modes.
//   clk, rst : clock and synchronous active-high reset
//   ser_in   : serial data bit, sampled when bit_vld and en are high
//   bit_vld  : qualifies ser_in
//   en       : detector enable; low clears history
//   ovl      : 1 = matches may share bits, 0 = N fresh bits per match
//   pat_in   : pattern value, pat_in[N-1] arrives first
//   pat_ld   : strobe loading pat_in and clearing history
//   cnt_clr  : clears the match counter
//   det      : registered one-cycle detect pulse
//   det_cnt  : saturating match count
//   cnt_sat  : high while det_cnt is at its maximum
module seq_pattern_detect
    import seq_pattern_detect_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             bit_vld,
    input  logic             en,
    input  logic             ovl,
    input  logic [N-1:0]     pat_in,
    input  logic             pat_ld,
    input  logic             cnt_clr,
    output logic             det,
    output logic [CNT_W-1:0] det_cnt,
    output logic             cnt_sat
);

    localparam int unsigned FILL_W = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

    state_t            state;
    logic [N-1:0]      hist;
    logic [N-1:0]      pat;
    logic [FILL_W-1:0] fill;

    logic [N-1:0]      hist_nxt;
    logic [FILL_W-1:0] fill_inc;
    logic              sample;
    logic              match;

    // A bit arriving with pat_ld is dropped, so it never feeds a match.
    always_comb begin
        hist_nxt = {hist[N-2:0], ser_in};
        fill_inc = (fill == FILL_FULL) ? fill : fill + 1'b1;
        sample   = en && bit_vld && !pat_ld;
        match    = sample && (hist_nxt == pat) && (fill >= FILL_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hist  <= '0;
            fill  <= '0;
            pat   <= '1;
            det   <= 1'b0;
        end else begin
            det <= match;
            if (pat_ld) begin
                pat <= pat_in;
            end
            if (!en) begin
                state <= IDLE;
                hist  <= '0;
                fill  <= '0;
            end else if (pat_ld) begin
                state <= FILL;
                hist  <= '0;
                fill  <= '0;
            end else if (bit_vld) begin
                hist <= hist_nxt;
                // Non-overlapping: restarting the fill count is enough to
                // demand N fresh bits; stale history is masked by fill.
                if (match && !ovl) begin
                    fill  <= '0;
                    state <= FILL;
                end else begin
                    fill  <= fill_inc;
                    state <= (fill_inc == FILL_FULL) ? HUNT : FILL;
                end
            end else if (state == IDLE) begin
                state <= FILL;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (cnt_clr),
        .count (det_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_pattern_detect.sv
// Self-checking bench for seq_pattern_detect: two instances (N=4/CNT_W=8
// and N=2/CNT_W=2) share stimulus and are compared every cycle against a
// bit-queue reference model, plus directed scenario checks.
module tb_seq_pattern_detect;

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ser_in = 1'b0;
    logic       bit_vld = 1'b0;
    logic       en = 1'b0;
    logic       ovl = 1'b1;
    logic [3:0] pat4 = 4'b0;
    logic [1:0] pat2 = 2'b0;
    logic       pat_ld = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       det4, sat4, det2, sat2;
    logic [7:0] cnt4;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;
    int pulses4 = 0;
    int pulses2 = 0;

    // reference model state
    bitq_t mq4, mq2;
    int    mpat4 = 15, mpat2 = 3;
    int    mcnt4 = 0, mcnt2 = 0;
    bit    mdet4 = 0, mdet2 = 0;

    always #5 clk = ~clk;

    seq_pattern_detect #(.N(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .ser_in(ser_in), .bit_vld(bit_vld), .en(en),
        .ovl(ovl), .pat_in(pat4), .pat_ld(pat_ld), .cnt_clr(cnt_clr),
        .det(det4), .det_cnt(cnt4), .cnt_sat(sat4)
    );

    seq_pattern_detect #(.N(2), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .ser_in(ser_in), .bit_vld(bit_vld), .en(en),
        .ovl(ovl), .pat_in(pat2), .pat_ld(pat_ld), .cnt_clr(cnt_clr),
        .det(det2), .det_cnt(cnt2), .cnt_sat(sat2)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // True when the last n bits received, oldest first, spell pat.
    function automatic bit tail_matches(input bitq_t q, input int n, input int pat);
        int v = 0;
        if (q.size() < n) return 1'b0;
        for (int i = q.size() - n; i < q.size(); i++) v = v * 2 + int'(q[i]);
        return v == pat;
    endfunction

    task automatic model_edge();
        bit m4, m2;
        m4 = 0;
        m2 = 0;
        if (rst) begin
            mq4.delete(); mq2.delete();
            mpat4 = 15; mpat2 = 3;
            mcnt4 = 0;  mcnt2 = 0;
        end else begin
            if (pat_ld) begin
                mpat4 = int'(pat4);
                mpat2 = int'(pat2);
                mq4.delete(); mq2.delete();
            end else if (!en) begin
                mq4.delete(); mq2.delete();
            end else if (bit_vld) begin
                mq4.push_back(ser_in);
                mq2.push_back(ser_in);
                m4 = tail_matches(mq4, 4, mpat4);
                m2 = tail_matches(mq2, 2, mpat2);
                if (m4 && !ovl) mq4.delete();
                if (m2 && !ovl) mq2.delete();
                while (mq4.size() > 8) void'(mq4.pop_front());
                while (mq2.size() > 8) void'(mq2.pop_front());
            end
            if (cnt_clr) begin
                mcnt4 = 0;
                mcnt2 = 0;
            end else begin
                if (m4 && mcnt4 < 255) mcnt4++;
                if (m2 && mcnt2 < 3) mcnt2++;
            end
        end
        mdet4 = m4;
        mdet2 = m2;
    endtask

    // One clock: inputs already applied; model follows the edge, DUT is
    // sampled 1 time unit later, then the caller may change inputs.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("det4", int'(det4), int'(mdet4));
        check_eq("cnt4", int'(cnt4), mcnt4);
        check_eq("sat4", int'(sat4), int'(mcnt4 == 255));
        check_eq("det2", int'(det2), int'(mdet2));
        check_eq("cnt2", int'(cnt2), mcnt2);
        check_eq("sat2", int'(sat2), int'(mcnt2 == 3));
        if (det4) pulses4++;
        if (det2) pulses2++;
        rst = 0; pat_ld = 0; cnt_clr = 0; bit_vld = 0;
    endtask

    task automatic send(input bit b);
        ser_in = b;
        bit_vld = 1;
        tick();
    endtask

    task automatic restart(input bit mode);
        rst = 1;
        tick();
        en = 1;
        ovl = mode;
        pat4 = 4'b1011;
        pat2 = 2'b11;
        pat_ld = 1;
        tick();
        pulses4 = 0;
        pulses2 = 0;
    endtask

    initial begin
        bit s030 [7] = '{1, 0, 1, 1, 0, 1, 1};
        bit s032 [7] = '{0, 1, 1, 1, 0, 1, 1};

        // reset state and all-ones default pattern
        rst = 1;
        tick();
        check_eq("rst_det", int'(det4), 0);
        check_eq("rst_cnt", int'(cnt4), 0);
        check_eq("rst_sat", int'(sat2), 0);
        en = 1;
        ovl = 1;
        for (int i = 0; i < 4; i++) send(1);
        check_eq("dflt_pat4_pulses", pulses4, 1);
        check_eq("dflt_pat2_pulses", pulses2, 3);

        // overlapping 1011 on 1,0,1,1,0,1,1
        restart(1);
        for (int i = 0; i < 7; i++) begin
            send(s030[i]);
            if (i == 3 || i == 6) check_eq("ovl_det_bit", int'(det4), 1);
        end
        check_eq("ovl_pulses", pulses4, 2);
        check_eq("ovl_cnt", int'(cnt4), 2);

        // non-overlapping, same stream
        restart(0);
        for (int i = 0; i < 7; i++) send(s030[i]);
        check_eq("novl_pulses", pulses4, 1);
        check_eq("novl_cnt", int'(cnt4), 1);

        // N=2 pattern 11 on 0,1,1,1,0,1,1
        restart(1);
        for (int i = 0; i < 7; i++) send(s032[i]);
        check_eq("n2_ovl_pulses", pulses2, 3);
        restart(0);
        for (int i = 0; i < 7; i++) send(s032[i]);
        check_eq("n2_novl_pulses", pulses2, 2);

        // bit_vld gaps between bits 2 and 3
        restart(1);
        send(1);
        send(0);
        for (int i = 0; i < 3; i++) tick();
        send(1);
        check_eq("gap_no_early", pulses4, 0);
        send(1);
        check_eq("gap_det", int'(det4), 1);
        tick();
        check_eq("gap_pulses", pulses4, 1);

        // counter saturation on N=2/CNT_W=2, then clear against a match
        restart(1);
        for (int i = 0; i < 6; i++) send(1);
        check_eq("sat_cnt", int'(cnt2), 3);
        check_eq("sat_flag", int'(sat2), 1);
        cnt_clr = 1;
        send(1);
        check_eq("clr_wins_cnt", int'(cnt2), 0);
        check_eq("clr_wins_det", int'(det2), 1);

        // reset on the completing bit
        restart(1);
        send(1);
        send(0);
        send(1);
        rst = 1;
        send(1);
        check_eq("rst_mid_det", int'(det4), 0);
        check_eq("rst_mid_cnt", int'(cnt4), 0);

        // pat_ld after 1,0,1 with a bit 1 riding on the strobe, then a 1
        restart(1);
        send(1);
        send(0);
        send(1);
        pat_ld = 1;
        send(1);
        send(1);
        tick();
        check_eq("patld_pulses", pulses4, 0);

        // randomized traffic
        restart(1);
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            en      = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 29) == 0) ovl = ~ovl;
            cnt_clr = ($urandom_range(0, 49) == 0);
            pat_ld  = ($urandom_range(0, 59) == 0);
            pat4    = 4'($urandom);
            pat2    = 2'($urandom);
            ser_in  = 1'($urandom);
            bit_vld = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
